pc_sequencer: RTL
=================

// Module: pc_sequencer
// PURPOSE
//  Owns the CPU program counter and sequences every PC update: sequential +4, jump, conditional branch.
//  Drives the jump/branch target adder (sign-extended 8-bit word offset, <<2, added to PC+4).
//  Holds the PC while instruction/data memory asserts BUSYWAIT.
//  Optionally inserts a one-cycle flush bubble after a taken redirect; counts taken redirects.
//  Sits between control unit/ALU (JUMP, BRANCH, BRANCH_NE, ZERO, OFFSET) and instruction memory (PC).
// PARAMETERS
//  RESET_PC        32'h0000_0000  PC value loaded on reset
//  CNT_W           16             width of TAKEN_CNT; saturating
//  REDIRECT_BUBBLE 0              1 = assert FLUSH for one cycle after each taken redirect
// PORTS
//  CLK        in   1   clock; all state updates on posedge
//  RESET      in   1   synchronous, active-low reset
//  BUSYWAIT   in   1   memory stall; 1 = hold PC and state
//  JUMP       in   1   unconditional jump from control unit
//  BRANCH     in   1   branch-if-equal (taken when ZERO=1)
//  BRANCH_NE  in   1   branch-if-not-equal (taken when ZERO=0)
//  ZERO       in   1   ALU zero flag for current instruction
//  OFFSET     in   8   signed word offset from instruction
//  PC         out  32  registered program counter to instruction memory
//  PC_PLUS4   out  32  PC + 4, combinational
//  FETCH_EN   out  1   registered; 1 = PC is a valid fetch address
//  FLUSH      out  1   registered; 1 = instruction currently in decode is wrong-path, kill it
//  TAKEN_CNT  out  CNT_W  registered count of taken jumps/branches, saturating
// BEHAVIOUR
//  Reset: posedge CLK with RESET=0 -> PC=RESET_PC, state=BOOT, FETCH_EN=0, FLUSH=0, TAKEN_CNT=0.
//   Reset has priority over every other input in every state, including mid-STALL/REDIRECT.
//  States: BOOT, RUN, STALL, REDIRECT (2-bit encoding).
//   BOOT:     FETCH_EN=0; next posedge -> RUN, PC unchanged.
//   RUN:      FETCH_EN=1. BUSYWAIT=1 -> STALL, PC held. BUSYWAIT=0 -> commit decision (below).
//   STALL:    FETCH_EN=1, PC held, inputs ignored while BUSYWAIT=1; first posedge with BUSYWAIT=0 -> commit decision.
//   REDIRECT: FLUSH=1, FETCH_EN=1; JUMP/BRANCH/BRANCH_NE ignored (wrong-path).
//             BUSYWAIT=0 -> PC<=PC+4, -> RUN; BUSYWAIT=1 -> hold, stay REDIRECT (FLUSH stays 1).
//  Commit decision:
//   taken = JUMP | (BRANCH & ZERO) | (BRANCH_NE & ~ZERO).
//   taken -> PC<=TARGET, TAKEN_CNT+=1 (hold at 2^CNT_W-1); next = REDIRECT if REDIRECT_BUBBLE else RUN.
//   not taken -> PC<=PC_PLUS4, next = RUN.
//  Arithmetic: PC_PLUS4 = PC + 32'd4; TARGET = PC_PLUS4 + {{22{OFFSET[7]}}, OFFSET, 2'b00}.
//   Both modulo 2^32: PC=32'hFFFF_FFFC not taken -> 32'h0; negative offsets wrap likewise.
//  Simultaneous controls: any combination with JUMP=1 is taken, counted once; BRANCH & BRANCH_NE
//   both high -> taken regardless of ZERO.
//  Latency: decision to new PC = 1 cycle; PC_PLUS4 follows PC combinationally in the same cycle.
//  FLUSH is 0 in every state except REDIRECT; with REDIRECT_BUBBLE=0 it is constant 0.
// STRUCTURE
//  Shared package cpu_ctrl_pkg: PC_W=32, OFF_W=8, state enum {BOOT,RUN,STALL,REDIRECT}, RESET_PC default.
//  Sub-module pc_target_adder: combinational sign-extend/shift/add (PC_PLUS4, OFFSET -> TARGET).
//  Top: state register, PC register, saturating counter, next-state/next-PC logic.
// TESTING
//  1 Reset: RESET=0 two cycles, then 1 -> PC=0, FETCH_EN 0 in BOOT, 1 next cycle; PC 0,4,8,12 on 3 more edges.
//  2 Branch: PC=0x10, BRANCH=1, ZERO=1, OFFSET=8'hFE -> PC=0x0C, TAKEN_CNT=1; ZERO=0 instead -> PC=0x14, count unchanged.
//  3 Stall: PC=0x20, JUMP=1, OFFSET=3, BUSYWAIT=1 for 3 cycles -> PC=0x20 held; first edge with BUSYWAIT=0 -> PC=0x30.
//  4 Bubble (REDIRECT_BUBBLE=1): taken jump -> FLUSH=1 exactly one cycle; JUMP=1 during it ignored; PC=target+4 after.
//  5 Wrap/saturate: PC=32'hFFFF_FFFC not taken -> PC=0; CNT_W=2, 5 taken -> TAKEN_CNT=3.
//  6 Reset mid-STALL: BUSYWAIT=1, RESET=0 one edge -> PC=RESET_PC, state BOOT, TAKEN_CNT=0, FLUSH=0.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | cpu_ctrl_pkg : shared widths, sequencer state encoding, taken rule |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package cpu_ctrl_pkg;

  localparam int          PC_W             = 32;
  localparam int          OFF_W            = 8;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_BOOT     = 2'd0,
    ST_RUN      = 2'd1,
    ST_STALL    = 2'd2,
    ST_REDIRECT = 2'd3
  } state_t;

  function automatic logic is_taken(input logic jump, input logic branch,
                                    input logic branch_ne, input logic zero);
    return jump | (branch & zero) | (branch_ne & ~zero);
  endfunction

endpackage
`default_nettype wire

// File: rtl/pc_target_adder.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | pc_target_adder : sign-extended word offset, <<2, added to PC+4    |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module pc_target_adder
  import cpu_ctrl_pkg::*;
(
  input  logic [PC_W-1:0]  i_pc_plus4,
  input  logic [OFF_W-1:0] i_offset,
  output logic [PC_W-1:0]  o_target
);

  logic [PC_W-1:0] w_off_ext;

  assign w_off_ext = {{(PC_W-OFF_W-2){i_offset[OFF_W-1]}}, i_offset, 2'b00};
  assign o_target  = i_pc_plus4 + w_off_ext;

endmodule
`default_nettype wire

// File: rtl/pc_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | pc_sequencer : program counter owner; sequential/jump/branch, stall|
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module pc_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC        = RESET_PC_DEFAULT,
  parameter int              CNT_W           = 16,
  parameter bit              REDIRECT_BUBBLE = 1'b0
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_busywait,
  input  logic             i_jump,
  input  logic             i_branch,
  input  logic             i_branch_ne,
  input  logic             i_zero,
  input  logic [OFF_W-1:0] i_offset,
  output logic [PC_W-1:0]  o_pc,
  output logic [PC_W-1:0]  o_pc_plus4,
  output logic             o_fetch_en,
  output logic             o_flush,
  output logic [CNT_W-1:0] o_taken_cnt
);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [PC_W-1:0]  r_pc;
  logic [PC_W-1:0]  w_pc_nxt;
  logic [PC_W-1:0]  w_pc_plus4;
  logic [PC_W-1:0]  w_target;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_fetch_en;
  logic             r_flush;
  logic             w_taken;

  assign w_pc_plus4 = r_pc + 32'd4;
  assign w_taken    = is_taken(i_jump, i_branch, i_branch_ne, i_zero);

  pc_target_adder u_target_adder (
    .i_pc_plus4 (w_pc_plus4),
    .i_offset   (i_offset),
    .o_target   (w_target)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_BOOT: w_state_nxt = ST_RUN;
      ST_RUN, ST_STALL: begin
        if (i_busywait) begin
          w_state_nxt = ST_STALL;
        end else if (w_taken) begin
          w_pc_nxt    = w_target;
          w_state_nxt = REDIRECT_BUBBLE ? ST_REDIRECT : ST_RUN;
          if (r_cnt != {CNT_W{1'b1}}) w_cnt_nxt = r_cnt + CNT_W'(1);
        end else begin
          w_pc_nxt    = w_pc_plus4;
          w_state_nxt = ST_RUN;
        end
      end
      ST_REDIRECT: begin
        // Control inputs belong to the wrong-path instruction here.
        if (!i_busywait) begin
          w_pc_nxt    = w_pc_plus4;
          w_state_nxt = ST_RUN;
        end
      end
      default: w_state_nxt = ST_BOOT;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state    <= ST_BOOT;
      r_pc       <= RESET_PC;
      r_cnt      <= '0;
      r_fetch_en <= 1'b0;
      r_flush    <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_pc       <= w_pc_nxt;
      r_cnt      <= w_cnt_nxt;
      r_fetch_en <= (w_state_nxt != ST_BOOT);
      r_flush    <= (w_state_nxt == ST_REDIRECT);
    end
  end

  assign o_pc        = r_pc;
  assign o_pc_plus4  = w_pc_plus4;
  assign o_fetch_en  = r_fetch_en;
  assign o_flush     = r_flush;
  assign o_taken_cnt = r_cnt;

endmodule
`default_nettype wire
